// File: rtl/window_scheduler.sv
// window_scheduler: raster-order 3x3 window sequencer with two line buffers.
// Optional stall counter output enabled by `WINDOW_SCHED_STATS_EN.
module window_scheduler #(
    parameter int PIX_W = 4,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         mode_in,
    output logic               busy,
    output logic               done,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIX_W-1:0]   in_pix,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [9*PIX_W-1:0] win,
    output logic               win_last,
    output logic [1:0]         mode
`ifdef WINDOW_SCHED_STATS_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [1:0]         mode_q;
    logic               done_q;
    logic               out_valid_q;
    logic               win_last_q;
    logic [9*PIX_W-1:0] win_q;
    logic [9*PIX_W-1:0] win_n;

    logic [PIX_W-1:0]   lb0_q [IMG_W];
    logic [PIX_W-1:0]   lb1_q [IMG_W];
    logic [PIX_W-1:0]   sr0_q [3];
    logic [PIX_W-1:0]   sr1_q [3];
    logic [PIX_W-1:0]   nc    [3];

    logic acc, ohs, col_wrap, frame_last, emit, go;

    assign go         = (state_q == S_IDLE) && start;
    assign acc        = in_valid && in_ready;
    assign ohs        = out_valid_q && out_ready;
    assign col_wrap   = (col_q == COL_LAST);
    assign frame_last = col_wrap && (row_q == ROW_LAST);
    assign emit       = acc && (state_q == S_STREAM) && (col_q >= CW'(2));

    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign win       = win_q;
    assign win_last  = win_last_q;
    assign mode      = mode_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: prime two rows, stream the rest, drain the final window
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_PRIME;
            S_PRIME:  if (acc && col_wrap && row_q == RW'(1)) state_d = S_STREAM;
            S_STREAM: if (acc && frame_last) state_d = S_DRAIN;
            S_DRAIN:  if (ohs) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: accept pixels while the output slot can take the result
    always_comb begin
        busy     = (state_q != S_IDLE);
        in_ready = 1'b0;
        case (state_q)
            S_PRIME:  in_ready = 1'b1;
            S_STREAM: in_ready = !out_valid_q || out_ready;
            default:  in_ready = 1'b0;
        endcase
    end

    // Raster position: column wraps into the next row
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (go) begin
            col_d = '0;
            row_d = '0;
        end else if (acc) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Candidate window: two stored columns plus the incoming column
    always_comb begin
        nc[0] = lb0_q[col_q];
        nc[1] = lb1_q[col_q];
        nc[2] = in_pix;
        win_n = '0;
        for (int r = 0; r < 3; r++) begin
            win_n[(r*3+0)*PIX_W +: PIX_W] = sr0_q[r];
            win_n[(r*3+1)*PIX_W +: PIX_W] = sr1_q[r];
            win_n[(r*3+2)*PIX_W +: PIX_W] = nc[r];
        end
    end

    // Counters, mode latch and the column shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            mode_q <= '0;
            for (int r = 0; r < 3; r++) begin
                sr0_q[r] <= '0;
                sr1_q[r] <= '0;
            end
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (go) mode_q <= mode_in;
            if (go || (acc && col_wrap)) begin
                for (int r = 0; r < 3; r++) begin
                    sr0_q[r] <= '0;
                    sr1_q[r] <= '0;
                end
            end else if (acc) begin
                for (int r = 0; r < 3; r++) begin
                    sr0_q[r] <= sr1_q[r];
                    sr1_q[r] <= nc[r];
                end
            end
        end
    end

    // Line buffers: read-before-write, contents need no reset
    always_ff @(posedge clk) begin
        if (acc) begin
            lb0_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= in_pix;
        end
    end

    // Output register: a new window replaces the old one without a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q == S_DRAIN) && ohs;
            if (emit) begin
                out_valid_q <= 1'b1;
                win_q       <= win_n;
                win_last_q  <= frame_last;
            end else if (ohs) begin
                out_valid_q <= 1'b0;
                win_last_q  <= 1'b0;
            end
        end
    end

`ifdef WINDOW_SCHED_STATS_EN
    logic [15:0] stall_q;

    // Saturating count of stalled output cycles while streaming
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (go) begin
            stall_q <= '0;
        end else if (state_q == S_STREAM && out_valid_q && !out_ready
                     && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/window_scheduler.md
Name: window_scheduler

Overview:
- Raster-stream sequencer for the 3x3 neighbourhood kernels: Gaussian smoothing, horizontal Sobel, vertical Sobel and the de-noise neighbour-count activation.
- Accepts one pixel per handshake, keeps two line buffers and a 3x3 shift window, and emits one registered window per interior pixel.
- Latches the kernel select per frame and drives it to the downstream kernel mux.
- Sits between the pixel source and the combinational kernel bank.

Parameters:
- PIX_W, 4, pixel width in bits.
- IMG_W, 64, frame width in pixels; must be >= 3.
- IMG_H, 64, frame height in pixels; must be >= 3.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle frame start request.
- mode_in  in  2  kernel select: 0 gaussian, 1 sobel_h, 2 sobel_v, 3 de-noise.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse after the last window handshake.
- in_valid  in  1  pixel valid.
- in_ready  out  1  pixel accept.
- in_pix  in  PIX_W  pixel, raster order.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accept.
- win  out  9*PIX_W  window; element [r][c] is at bits (r*3+c)*PIX_W +: PIX_W.
  - r=0 is the oldest row; c=0 is the leftmost column.
- win_last  out  1  marks the final window of the frame.
- mode  out  2  latched kernel select.

Behaviour:
- Reset:
  - State IDLE.
  - busy, done, in_ready, out_valid and win_last are 0; mode is 0; win is 0; col/row counters are 0.
  - Line-buffer contents are don't-care.
- States: IDLE, PRIME, STREAM, DRAIN.
- IDLE:
  - start=1 latches mode_in into mode, clears counters, sets busy and moves to PRIME.
  - start is ignored in every other state.
- PRIME covers rows 0 and 1. Pixels are stored only; no windows are emitted.
  - Go to STREAM when pixel (1, IMG_W-1) is accepted.
- STREAM covers rows 2..IMG_H-1.
  - Every accepted pixel shifts a new column {lb0[col], lb1[col], in_pix} into the window.
  - When col >= 2, the accepted pixel loads win and sets out_valid on the next edge (latency 1).
  - The window is centred at (row-1, col-1).
- DRAIN:
  - Entered when pixel (IMG_H-1, IMG_W-1) is accepted; that pixel's window is emitted with win_last=1.
  - When that window handshakes: done pulses for 1 cycle, busy drops and the FSM returns to IDLE.
- Line buffers:
  - On each accept, lb0[col] <= lb1[col] and lb1[col] <= in_pix.
  - Read-before-write within the same cycle.
- Handshake:
  - in_ready = (PRIME) or (STREAM and (!out_valid or out_ready)). It is 0 in IDLE and DRAIN.
  - Transfers happen only when valid and ready are both high.
  - out_valid, win and win_last hold stable until out_ready.
  - A simultaneous output handshake and input accept that produces a new window keeps out_valid=1 with the new data. There is no bubble.
- Counters:
  - col wraps from IMG_W-1 to 0, incrementing row.
  - The window shift register is reset at every col wrap, so no window spans two rows.
- Window count: (IMG_W-2)*(IMG_H-2) per frame.
- Stalls: in_valid=0 mid-row stalls without side effects.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.

Optional Feature:
- Macro: WINDOW_SCHED_STATS_EN.
- Defined:
  - Adds output stall_cnt (16 bits), which counts cycles in STREAM with out_valid=1 and out_ready=0.
  - The count saturates at 16'hFFFF, clears on accepted start, and holds after done.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic frame:
  - Stimulus: IMG_W=5, IMG_H=4, mode_in=1, pixel p(r,c)=(r*5+c) mod 16, in_valid=1, out_ready=1.
  - Response: 6 windows.
  - First window: [0][0]=0, [1][1]=6, [2][2]=12, with out_valid one cycle after pixel 12 is accepted.
  - Last window: [0][0]=7, [1][1]=13, [2][2]=3, with win_last=1.
  - done pulses 1 cycle after the last handshake; mode=1 throughout.
- Backpressure:
  - Stimulus: same frame with out_ready toggled 1,0,0,1.
  - Response: win stable while stalled; in_ready=0 during stalls; still exactly 6 windows in order.
- Source gaps:
  - Stimulus: in_valid low every other cycle.
  - Response: same 6 windows; no spurious out_valid.
- Start while busy:
  - Stimulus: start=1 with mode_in=3 mid-frame.
  - Response: ignored; mode stays 1; frame completes normally.
- Reset mid-frame:
  - Stimulus: rst_n=0 after 12 pixels, then a new frame.
  - Response: all outputs return to reset values; the new frame's first window equals the basic-frame first window.
- WINDOW_SCHED_STATS_EN:
  - Stimulus: hold out_ready=0 for 7 cycles on the first window.
  - Response: stall_cnt=7 at done; it resets to 0 on the next start.
